fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NUM_REQ producers share one synchronous FIFO write port.
Each producer uses a valid/ready/last handshake. The arbiter grants one producer at a time and holds the grant for a burst, which ends on a last beat or after BURST_MAX beats.
It drives the FIFO's wr_en/wr_data and respects the FIFO's fifo_full status. It sits directly in front of the FIFO top on the write side.

Parameters:
- DATA_SIZE, 8, width of one data word (matches the FIFO data width).
- NUM_REQ, 4, number of producers, 2..16.
- BURST_MAX, 4, maximum beats per grant, 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-producer data valid.
- req_last  in  NUM_REQ  per-producer end-of-burst marker, qualified by valid.
- req_data  in  NUM_REQ*DATA_SIZE  packed producer data; producer i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready  out  NUM_REQ  per-producer accept.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_SIZE  FIFO write data.
- grant_id  out  GW  index of the current owner; GW = max(1, clog2(NUM_REQ)).
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (asynchronous, reset_n=0), all registers cleared:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Outputs: fifo_wr_en=0, req_ready=0, busy=0, fifo_wr_data=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the selection into grant_id and go to GRANT at the next edge; beat_cnt:=0.
  - If no req_valid is set, stay in IDLE.
  - Arbitration latency: 1 cycle from request to grant. req_ready stays 0 in IDLE.
- GRANT (let g = grant_id):
  - req_ready[g] = ~fifo_full; all other req_ready bits = 0 (combinational).
  - A beat is accepted when req_valid[g] & ~fifo_full.
  - fifo_wr_en = accepted beat.
  - fifo_wr_data = slice g of req_data when in GRANT, else 0.
  - On each accepted beat, beat_cnt increments.
  - Burst end occurs on an accepted beat where req_last[g]=1 or beat_cnt==BURST_MAX-1.
  - At burst end: rr_ptr := (g+1) mod NUM_REQ, then return to IDLE. This leaves 1 bubble cycle between bursts.
  - If req_valid[g] drops mid-burst, the grant is held; there is no timeout.
- fifo_full=1: no beat is accepted, beat_cnt and state are held, and fifo_wr_en=0. fifo_full is used the same cycle with no registering, so the FIFO is never overrun.
- Round-robin wrap: when g = NUM_REQ-1, rr_ptr wraps to 0.
- Simultaneous requests: exactly one grant is issued. Fairness: each active requester is served within NUM_REQ bursts.
- req_last on a non-accepted cycle has no effect.
- beat_cnt width = clog2(BURST_MAX+1); it never exceeds BURST_MAX-1 when stored.
- Reset asserted mid-burst: the burst is abandoned immediately, req_ready drops asynchronously, and after release the FSM is in IDLE with rr_ptr=0.
- No data storage in the arbiter: zero-latency pass-through of data in GRANT.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GRANT);
  - the GW computation as a function;
  - default localparams for DATA_SIZE and NUM_REQ.
- One natural sub-module: rr_pick.
  - Combinational: inputs req vector and rr_ptr; outputs winner index and any_req.
  - Implemented as a double-width masked priority search.
  - Instantiated once in the arbiter.

Test Plan (NUM_REQ=4, DATA_SIZE=8, BURST_MAX=4):
- Reset: hold reset_n=0 with req_valid=4'hF → req_ready=0, fifo_wr_en=0, grant_id=0, busy=0. Release reset → busy=1 one cycle later with grant_id=0.
- Single producer: producer 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the 3rd → fifo_wr_en for exactly 3 cycles with data A1,A2,A3. Return to IDLE; rr_ptr=3.
- BURST_MAX cut: producer 1 keeps valid=1 with last=0 for 6 beats → 4 beats written, 1 idle bubble, then a re-grant to producer 1 (sole requester) that writes the remaining 2 beats.
- Round robin: all 4 producers continuously valid with last on every beat → grant_id sequence 0,1,2,3,0 and each writes 1 beat per grant.
- Back-pressure: fifo_full=1 for 3 cycles mid-burst of producer 0 → req_ready[0]=0, no writes, beat_cnt held. Burst resumes with no lost or duplicated data.
- Reset mid-burst: assert reset_n=0 after beat 2 of producer 3 → outputs zero immediately. After release with producers 1 and 3 valid, producer 1 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
package fifo_wr_arbiter_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a producer index; never narrower than one bit.
    function automatic int grant_width(input int num_req);
        int w;
        w = $clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_REQ.
// The request vector is doubled so the wrap becomes a plain upward search.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               any_req
);

    localparam int W2 = 2 * NUM_REQ;

    logic [W2-1:0] dbl;
    logic [W2-1:0] masked;
    logic          found;
    int unsigned   hit;
    int unsigned   pos;

    // Mask off doubled bits below ptr, then take the lowest remaining set bit.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        found  = 1'b0;
        hit    = 0;
        pos    = 0;
        for (int unsigned i = 0; i < W2; i++) begin
            masked[i] = dbl[i] && (i >= 32'(ptr));
        end
        for (int unsigned i = 0; i < W2; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                hit   = i;
            end
        end
        pos     = (hit >= 32'(NUM_REQ)) ? (hit - 32'(NUM_REQ)) : hit;
        winner  = GW'(pos);
        any_req = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// valid/ready/last producers. Data passes straight through while granted.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int DATA_SIZE = DEF_DATA_SIZE,
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int BURST_MAX = DEF_BURST_MAX,
    localparam int GW        = grant_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_SIZE-1:0]         fifo_wr_data,
    output logic [GW-1:0]                grant_id,
    output logic                         busy
);

    localparam int             BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST_MAX - 1);
    localparam logic [GW-1:0]  LAST_ID   = GW'(NUM_REQ - 1);

    arb_state_t     state, state_nxt;
    logic [GW-1:0]  rr_ptr, rr_nxt;
    logic [GW-1:0]  grant_nxt;
    logic [BW-1:0]  beat_cnt, beat_nxt;

    logic [GW-1:0]          pick_id;
    logic                   any_req;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_SIZE-1:0]   sel_data;
    logic [NUM_REQ-1:0]     owner_hot;
    logic                   accept;
    logic                   burst_end;

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (pick_id),
        .any_req (any_req)
    );

    // Route the current owner's handshake and data onto single-bit/word buses.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        owner_hot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[i*DATA_SIZE +: DATA_SIZE];
                owner_hot[i] = 1'b1;
            end
        end
    end

    // Next-state and output decode; fifo_full gates acceptance in the same cycle.
    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        grant_nxt    = grant_id;
        beat_nxt     = beat_cnt;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        accept       = 1'b0;
        burst_end    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = pick_id;
                    beat_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy         = 1'b1;
                fifo_wr_data = sel_data;
                req_ready    = fifo_full ? '0 : owner_hot;
                accept       = sel_valid && !fifo_full;
                fifo_wr_en   = accept;
                if (accept) begin
                    burst_end = sel_last || (beat_cnt == BEAT_LAST);
                    if (burst_end) begin
                        beat_nxt  = '0;
                        rr_nxt    = (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, owner and beat counter; reset abandons any burst at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_SIZE=8, BURST_MAX=4).
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BM = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic [1:0]        grant_id;
    logic              busy;

    beat_t       pq[NR][$];
    wr_t         exp_q[$];
    int unsigned wr_cyc[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    wr_t         mon_e;

    fifo_wr_arbiter #(
        .DATA_SIZE (DW),
        .NUM_REQ   (NR),
        .BURST_MAX (BM)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Producer model: present queue heads, pop whatever was accepted at the edge.
    initial begin : driver
        logic [NR-1:0] acc;
        beat_t b;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    b = pq[i][0];
                    req_valid[i]           = 1'b1;
                    req_last[i]            = b.last;
                    req_data[i*DW +: DW]   = b.data;
                end else begin
                    req_valid[i]           = 1'b0;
                    req_last[i]            = 1'b0;
                    req_data[i*DW +: DW]   = '0;
                end
            end
        end
    end

    // Monitor: every FIFO write must match the next expected (owner, data).
    always @(negedge clk) begin
        if (reset_n === 1'b1 && fifo_wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_beat: unexpected write id=%0d data=0x%h, none expected", grant_id, fifo_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({grant_id, fifo_wr_data} !== mon_e) begin
                    errors++;
                    $display("FAIL wr_beat: got id=%0d data=0x%h want id=%0d data=0x%h",
                             grant_id, fifo_wr_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        pq[p].push_back(b);
    endtask

    task automatic expect_wr(input int p, input logic [7:0] d);
        wr_t w;
        w.id   = 2'(p);
        w.data = d;
        exp_q.push_back(w);
    endtask

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < NR; i++) if (pq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while (!all_empty() && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(all_empty()), 32'd1);
    endtask

    task automatic wait_writes(input int unsigned n, input string name);
        int unsigned t;
        t = 0;
        while (wr_cyc.size() < n && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk(name, 32'(wr_cyc.size() >= n), 32'd1);
    endtask

    task automatic chk_gap(input string name, input int k, input int unsigned want);
        int unsigned act;
        act = (wr_cyc.size() > k + 1) ? (wr_cyc[k+1] - wr_cyc[k]) : 32'd0;
        chk(name, act, want);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        reset_n   = 1'b0;
        fifo_full = 1'b0;

        // Reset held with all producers requesting.
        for (int i = 0; i < NR; i++) push_beat(i, 8'(8'h10 + i), 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", 32'(fifo_wr_data), 32'h0);
        for (int i = 0; i < NR; i++) expect_wr(i, 8'(8'h10 + i));
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", 32'(busy), 32'h1);
        chk("rel_grant", 32'(grant_id), 32'h0);
        wait_drain("drain_reset");
        chk("rr_wrap", 32'(dut.rr_ptr), 32'h0);

        // Round robin: everyone requesting, one-beat bursts.
        wr_cyc.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) begin
                push_beat(i, 8'(8'h20 + 16 * k + i), 1'b1);
                expect_wr(i, 8'(8'h20 + 16 * k + i));
            end
        wait_drain("drain_rr");
        for (int k = 0; k < 7; k++) chk_gap("rr_gap", k, 2);
        chk("rr_ptr_after_rr", 32'(dut.rr_ptr), 32'h0);

        // Single producer 2, three beats with last on the third.
        wr_cyc.delete();
        push_beat(2, 8'hA1, 1'b0);
        push_beat(2, 8'hA2, 1'b0);
        push_beat(2, 8'hA3, 1'b1);
        expect_wr(2, 8'hA1);
        expect_wr(2, 8'hA2);
        expect_wr(2, 8'hA3);
        wait_drain("drain_single");
        chk_gap("single_gap", 0, 1);
        chk_gap("single_gap", 1, 1);
        chk("single_rr_ptr", 32'(dut.rr_ptr), 32'h3);
        chk("single_idle", 32'(busy), 32'h0);

        // Burst cut at BURST_MAX, then re-grant to the same sole requester.
        wr_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            push_beat(1, 8'(8'hB1 + k), (k == 5));
            expect_wr(1, 8'(8'hB1 + k));
        end
        wait_drain("drain_cut");
        chk_gap("cut_gap0", 0, 1);
        chk_gap("cut_gap1", 1, 1);
        chk_gap("cut_gap2", 2, 1);
        chk_gap("cut_bubble", 3, 2);
        chk_gap("cut_gap4", 4, 1);
        chk("cut_rr_ptr", 32'(dut.rr_ptr), 32'h2);

        // Back-pressure: FIFO full for three cycles after beat 2 of producer 0.
        wr_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            push_beat(0, 8'(8'hC1 + k), (k == 3));
            expect_wr(0, 8'(8'hC1 + k));
        end
        wait_writes(2, "bp_two_beats");
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("bp_beat_cnt", 32'(dut.beat_cnt), 32'h2);
            @(posedge clk);
            #2;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("bp_resume_ready", 32'(req_ready), 32'h1);
        wait_drain("drain_bp");
        chk_gap("bp_gap0", 0, 1);
        chk_gap("bp_stall", 1, 4);
        chk_gap("bp_gap2", 2, 1);
        chk("bp_rr_ptr", 32'(dut.rr_ptr), 32'h1);

        // Reset after beat 2 of producer 3; pointer returns to 0.
        wr_cyc.delete();
        for (int k = 0; k < 4; k++) push_beat(3, 8'(8'hD1 + k), 1'b0);
        expect_wr(3, 8'hD1);
        expect_wr(3, 8'hD2);
        wait_writes(2, "mid_two_beats");
        reset_n = 1'b0;
        #1;
        chk("mid_ready", 32'(req_ready), 32'h0);
        chk("mid_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_grant", 32'(grant_id), 32'h0);
        chk("mid_data", 32'(fifo_wr_data), 32'h0);
        chk("mid_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        pq[3].delete();
        push_beat(1, 8'hE1, 1'b1);
        push_beat(3, 8'hE3, 1'b1);
        expect_wr(1, 8'hE1);
        expect_wr(3, 8'hE3);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_grant", 32'(grant_id), 32'h1);
        wait_drain("drain_post_rst");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
